// File: rtl/exec_stage_md.sv
// exec_stage_md: execute stage with single-cycle ALU/branch resolution and an
// iterative RV32M/RV64M multiply/divide unit that stalls upstream through busy.
module exec_stage_md #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stallIn,
   input  logic            validIn,
   input  logic [XLEN-1:0] rs1Val,
   input  logic [XLEN-1:0] rs2Val,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic            selA,
   input  logic [1:0]      selB,
   input  logic [3:0]      aluOp,
   input  logic            mdEn,
   input  logic [2:0]      mdOp,
   input  logic            branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic [1:0]      memOpIn,
   input  logic [1:0]      memSizeIn,
   output logic            busy,
   output logic            outValid,
   output logic [XLEN-1:0] exResult,
   output logic            pcSel,
   output logic [XLEN-1:0] pcVect,
   output logic [1:0]      memOp,
   output logic [1:0]      memSize,
   output logic [XLEN-1:0] memDin
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   state_t            state_q;
   logic [SHW-1:0]    cnt_q;
   logic [2*XLEN:0]   acc_q, acc_d, sh;
   logic [XLEN-1:0]   opb_q, rs2_q, res_q;
   logic [2:0]        mdop_q;
   logic              neg_q;
   logic [XLEN-1:0]   a, b, alu, jt, a_mag, b_mag, spec_res, qr, fin;
   logic [XLEN:0]     hi_sum, rem_t;
   logic [2*XLEN-1:0] prod;
   logic              a_sg, b_sg, a_ng, b_ng, by_zero, ovf;
   always_comb begin
      a = selA ? pc : rs1Val;
      b = selB == 2'b00 ? rs2Val : selB == 2'b01 ? imm : selB == 2'b10 ? XLEN'(4) : '0;
      jt = rs1Val + imm;
      case (aluOp)
         4'h0: alu = a + b;
         4'h1: alu = a - b;
         4'h2: alu = a & b;
         4'h3: alu = a | b;
         4'h4: alu = a ^ b;
         4'h5: alu = a << b[SHW-1:0];
         4'h6: alu = a >> b[SHW-1:0];
         4'h7: alu = $signed(a) >>> b[SHW-1:0];
         4'h8, 4'hC: alu = XLEN'($signed(a) < $signed(b));
         4'h9, 4'hE: alu = XLEN'(a < b);
         4'hA: alu = XLEN'(a == b);
         4'hB: alu = XLEN'(a != b);
         4'hD: alu = XLEN'($signed(a) >= $signed(b));
         default: alu = XLEN'(a >= b);
      endcase
   end
   always_comb begin
      a_sg = mdOp == 3'd1 || mdOp == 3'd2 || (mdOp[2] && !mdOp[0]);
      b_sg = mdOp == 3'd1 || (mdOp[2] && !mdOp[0]);
      a_ng = a_sg && rs1Val[XLEN-1];
      b_ng = b_sg && rs2Val[XLEN-1];
      a_mag = a_ng ? -rs1Val : rs1Val;
      b_mag = b_ng ? -rs2Val : rs2Val;
      by_zero = mdOp[2] && rs2Val == '0;
      ovf = mdOp[2] && !mdOp[0] && rs1Val == MIN && rs2Val == '1;
      spec_res = by_zero ? (mdOp[1] ? rs1Val : '1) : (mdOp[1] ? '0 : MIN);
      // acc holds {hi, lo} for shift-add multiply or {remainder, quotient} for restoring divide
      hi_sum = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opb_q} : '0);
      sh = {acc_q[2*XLEN-1:0], 1'b0};
      rem_t = sh[2*XLEN:XLEN];
      acc_d = !mdop_q[2] ? {1'b0, hi_sum, acc_q[XLEN-1:1]} :
              rem_t >= {1'b0, opb_q} ? {rem_t - {1'b0, opb_q}, sh[XLEN-1:1], 1'b1} : sh;
      prod = neg_q ? -acc_d[2*XLEN-1:0] : acc_d[2*XLEN-1:0];
      qr = mdop_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      fin = !mdop_q[2] ? (mdop_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
            neg_q ? -qr : qr;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         rs2_q    <= '0;
         res_q    <= '0;
         mdop_q   <= '0;
         neg_q    <= 1'b0;
         outValid <= 1'b0;
         exResult <= '0;
         pcSel    <= 1'b0;
         pcVect   <= '0;
         memOp    <= 2'b00;
         memSize  <= 2'b00;
         memDin   <= '0;
      end else begin
         case (state_q)
            IDLE: if (!stallIn) begin
               if (validIn && mdEn) begin
                  outValid <= 1'b0;
                  pcSel    <= 1'b0;
                  memOp    <= 2'b00;
                  mdop_q   <= mdOp;
                  neg_q    <= (mdOp[2] && mdOp[1]) ? a_ng : a_ng ^ b_ng;
                  rs2_q    <= rs2Val;
                  acc_q    <= {{(XLEN+1){1'b0}}, a_mag};
                  opb_q    <= b_mag;
                  cnt_q    <= SHW'(XLEN-1);
                  res_q    <= spec_res;
                  state_q  <= (by_zero || ovf) ? DONE : BUSY;
               end else begin
                  outValid <= validIn;
                  exResult <= alu;
                  pcSel    <= validIn && ((branch && |alu) || jal || jalr);
                  pcVect   <= jalr ? {jt[XLEN-1:1], 1'b0} : pc + imm;
                  memOp    <= validIn ? memOpIn : 2'b00;
                  memSize  <= memSizeIn;
                  memDin   <= rs2Val;
               end
            end
            BUSY: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == '0) begin
                  res_q   <= fin;
                  state_q <= DONE;
               end
            end
            default: if (!stallIn) begin
               exResult <= res_q;
               outValid <= 1'b1;
               pcSel    <= 1'b0;
               memOp    <= 2'b00;
               memDin   <= rs2_q;
               state_q  <= IDLE;
            end
         endcase
      end
   end
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_exec_stage_md.sv
// tb_exec_stage_md: checks a 32-bit and a 64-bit exec_stage_md against an
// arithmetic reference model, with vector tables and stall/reset sequences.
module tb_exec_stage_md;
   logic        clk = 1'b0;
   logic        rst32 = 1'b1, rst64 = 1'b1, stall = 1'b0, valid = 1'b0;
   logic [63:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
   logic        selA = 1'b0, mdEn = 1'b0, branch = 1'b0, jal = 1'b0, jalr = 1'b0;
   logic [1:0]  selB = '0, memOpIn = '0, memSizeIn = '0;
   logic [3:0]  aluOp = '0;
   logic [2:0]  mdOp = '0;
   logic        busy32, ov32, ps32, busy64, ov64, ps64;
   logic [31:0] ex32, pv32, md32;
   logic [63:0] ex64, pv64, md64;
   logic [1:0]  mo32, ms32, mo64, ms64;
   logic        w64 = 1'b0;
   int          errors = 0, checks = 0;
   logic        busy_o, ov_o, ps_o;
   logic [63:0] ex_o, pv_o, md_o;
   logic [1:0]  mo_o, ms_o;
   always #5 clk = ~clk;
   exec_stage_md #(.XLEN(32)) dut32 (
      .clk(clk), .reset(rst32), .stallIn(stall), .validIn(valid),
      .rs1Val(rs1[31:0]), .rs2Val(rs2[31:0]), .imm(imm[31:0]), .pc(pc[31:0]),
      .selA(selA), .selB(selB), .aluOp(aluOp), .mdEn(mdEn), .mdOp(mdOp),
      .branch(branch), .jal(jal), .jalr(jalr), .memOpIn(memOpIn), .memSizeIn(memSizeIn),
      .busy(busy32), .outValid(ov32), .exResult(ex32), .pcSel(ps32), .pcVect(pv32),
      .memOp(mo32), .memSize(ms32), .memDin(md32));
   exec_stage_md #(.XLEN(64)) dut64 (
      .clk(clk), .reset(rst64), .stallIn(stall), .validIn(valid),
      .rs1Val(rs1), .rs2Val(rs2), .imm(imm), .pc(pc),
      .selA(selA), .selB(selB), .aluOp(aluOp), .mdEn(mdEn), .mdOp(mdOp),
      .branch(branch), .jal(jal), .jalr(jalr), .memOpIn(memOpIn), .memSizeIn(memSizeIn),
      .busy(busy64), .outValid(ov64), .exResult(ex64), .pcSel(ps64), .pcVect(pv64),
      .memOp(mo64), .memSize(ms64), .memDin(md64));
   assign busy_o = w64 ? busy64 : busy32;
   assign ov_o   = w64 ? ov64 : ov32;
   assign ps_o   = w64 ? ps64 : ps32;
   assign ex_o   = w64 ? ex64 : {32'd0, ex32};
   assign pv_o   = w64 ? pv64 : {32'd0, pv32};
   assign md_o   = w64 ? md64 : {32'd0, md32};
   assign mo_o   = w64 ? mo64 : mo32;
   assign ms_o   = w64 ? ms64 : ms32;

   typedef struct {
      logic selA; logic [1:0] selB; logic [3:0] op;
      logic [63:0] rs1, rs2, imm, pc;
      logic v, br, jl, jr;
      logic [63:0] e_res; logic e_ps; logic [63:0] e_pv;
   } vec_t;
   vec_t vt[19];

   function automatic int xlen();
      return w64 ? 64 : 32;
   endfunction
   function automatic logic [63:0] mask();
      return w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_busy"}, 64'(busy_o), 0);
      chk({nm, "_outValid"}, 64'(ov_o), 0);
      chk({nm, "_exResult"}, ex_o, 0);
      chk({nm, "_pcSel"}, 64'(ps_o), 0);
      chk({nm, "_pcVect"}, pv_o, 0);
      chk({nm, "_memOp"}, 64'(mo_o), 0);
      chk({nm, "_memDin"}, md_o, 0);
   endtask

   function automatic logic [63:0] alu_ref(int xl, logic [3:0] op, logic [63:0] a, logic [63:0] b);
      logic [63:0] m, r;
      logic signed [64:0] sa, sb;
      int sh;
      m = xl == 64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      a &= m;
      b &= m;
      sa = xl == 64 ? {a[63], a} : {{33{a[31]}}, a[31:0]};
      sb = xl == 64 ? {b[63], b} : {{33{b[31]}}, b[31:0]};
      sh = xl == 64 ? int'(b[5:0]) : int'(b[4:0]);
      case (op)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = a << sh;
         4'h6: r = a >> sh;
         4'h7: r = 64'(sa >>> sh);
         4'h8, 4'hC: r = 64'(sa < sb);
         4'h9, 4'hE: r = 64'(a < b);
         4'hA: r = 64'(a == b);
         4'hB: r = 64'(a != b);
         4'hD: r = 64'(sa >= sb);
         default: r = 64'(a >= b);
      endcase
      return r & m;
   endfunction

   function automatic logic [63:0] md_ref(int xl, logic [2:0] op, logic [63:0] x, logic [63:0] y);
      logic [63:0] m, mn;
      logic signed [129:0] xs, ys, xu, yu, p;
      m = xl == 64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      mn = 64'd1 << (xl - 1);
      x &= m;
      y &= m;
      xu = {66'd0, x};
      yu = {66'd0, y};
      xs = xl == 64 ? {{66{x[63]}}, x} : {{98{x[31]}}, x[31:0]};
      ys = xl == 64 ? {{66{y[63]}}, y} : {{98{y[31]}}, y[31:0]};
      if (op[2] && y == 0) p = op[1] ? xu : '1;
      else if (op[2] && !op[0] && x == mn && y == m) p = op[1] ? '0 : xu;
      else begin
         case (op)
            3'd0: p = xs * ys;
            3'd1: p = (xs * ys) >>> xl;
            3'd2: p = (xs * yu) >>> xl;
            3'd3: p = (xu * yu) >>> xl;
            3'd4: p = xs / ys;
            3'd5: p = xu / yu;
            3'd6: p = xs % ys;
            default: p = xu % yu;
         endcase
      end
      return p[63:0] & m;
   endfunction

   function automatic logic [63:0] rnd_val();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = 0;
         1: v = 1;
         2: v = '1;
         3: v = 64'd1 << (xlen() - 1);
         4: v = 64'($urandom_range(0, 20));
         default: v = {$urandom, $urandom};
      endcase
      return v & mask();
   endfunction

   // issues one M op, scrambles inputs while busy, and checks latency and result
   task automatic run_md(string nm, logic [2:0] op, logic [63:0] x, logic [63:0] y, logic [63:0] exp);
      int n;
      logic sp;
      logic [63:0] m;
      m = mask();
      x &= m;
      y &= m;
      sp = op[2] && (y == 0 || (!op[0] && x == (64'd1 << (xlen() - 1)) && y == m));
      stall = 0; valid = 1; mdEn = 1; mdOp = op; rs1 = x; rs2 = y;
      step();
      chk({nm, "_busy_issue"}, 64'(busy_o), 1);
      chk({nm, "_bubble"}, 64'(ov_o), 0);
      n = 0;
      while (busy_o && n < 200) begin
         rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; mdOp = 3'($urandom);
         valid = 1'($urandom); mdEn = 1'($urandom); aluOp = 4'($urandom); memOpIn = 2'($urandom);
         jal = 1'($urandom);
         step();
         n++;
      end
      valid = 0; mdEn = 0; jal = 0;
      chk({nm, "_busy_cycles"}, 64'(n), sp ? 64'd1 : 64'(xlen() + 1));
      chk({nm, "_result"}, ex_o, exp & m);
      chk({nm, "_outValid"}, 64'(ov_o), 1);
      chk({nm, "_pcSel"}, 64'(ps_o), 0);
      chk({nm, "_memOp"}, 64'(mo_o), 0);
      chk({nm, "_memDin"}, md_o, y);
   endtask

   task automatic run_alu_rand();
      logic [63:0] m, a, b, r, pv;
      int k;
      m = mask();
      rs1 = rnd_val(); rs2 = rnd_val(); imm = rnd_val(); pc = rnd_val();
      selA = 1'($urandom); selB = 2'($urandom); aluOp = 4'($urandom);
      valid = $urandom_range(0, 3) != 0;
      mdEn = !valid && 1'($urandom);
      k = $urandom_range(0, 3);
      branch = k == 1; jal = k == 2; jalr = k == 3;
      memOpIn = 2'($urandom); memSizeIn = 2'($urandom);
      a = selA ? pc : rs1;
      b = selB == 0 ? rs2 : selB == 1 ? imm : selB == 2 ? 64'd4 : 64'd0;
      r = alu_ref(xlen(), aluOp, a, b);
      pv = jalr ? ((rs1 + imm) & m & ~64'd1) : ((pc + imm) & m);
      step();
      chk("rand_alu_result", ex_o, r);
      chk("rand_alu_pcSel", 64'(ps_o), 64'(valid && ((branch && r != 0) || jal || jalr)));
      chk("rand_alu_pcVect", pv_o, pv);
      chk("rand_alu_outValid", 64'(ov_o), 64'(valid));
      chk("rand_alu_memOp", 64'(mo_o), valid ? 64'(memOpIn) : 64'd0);
      valid = 0; mdEn = 0; branch = 0; jal = 0; jalr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1, 2, 4'h0, 0, 0, 0, 'h100, 1, 0, 0, 0, 'h104, 0, 'h100};
      vt[1]  = '{0, 0, 4'hA, 5, 5, 'h10, 'h200, 1, 1, 0, 0, 1, 1, 'h210};
      vt[2]  = '{1, 2, 4'h0, 'h1003, 0, 0, 'h300, 1, 0, 0, 1, 'h304, 1, 'h1002};
      vt[3]  = '{1, 2, 4'h0, 0, 0, 'h20, 'h400, 0, 0, 1, 0, 'h404, 0, 'h420};
      vt[4]  = '{0, 0, 4'h1, 3, 5, 0, 0, 1, 0, 0, 0, 'hFFFF_FFFE, 0, 0};
      vt[5]  = '{0, 1, 4'h7, 'h8000_0000, 0, 4, 0, 1, 0, 0, 0, 'hF800_0000, 0, 4};
      vt[6]  = '{0, 1, 4'h6, 'h8000_0000, 0, 4, 0, 1, 0, 0, 0, 'h0800_0000, 0, 4};
      vt[7]  = '{0, 0, 4'h5, 1, 'h23, 0, 0, 1, 0, 0, 0, 8, 0, 0};
      vt[8]  = '{0, 0, 4'h8, 'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
      vt[9]  = '{0, 0, 4'h9, 'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      vt[10] = '{0, 0, 4'hC, 'hFFFF_FFFF, 1, 8, 'h10, 1, 1, 0, 0, 1, 1, 'h18};
      vt[11] = '{0, 0, 4'hB, 5, 5, 8, 'h10, 1, 1, 0, 0, 0, 0, 'h18};
      vt[12] = '{0, 0, 4'hF, 'hFFFF_FFFF, 1, 'h40, 'h1000, 1, 1, 0, 0, 1, 1, 'h1040};
      vt[13] = '{0, 3, 4'h0, 'hDEAD_BEEF, 7, 0, 0, 1, 0, 0, 0, 'hDEAD_BEEF, 0, 0};
      vt[14] = '{0, 0, 4'h4, 'hF0F0, 'hFF00, 0, 0, 1, 0, 0, 0, 'h0FF0, 0, 0};
      vt[15] = '{0, 0, 4'h2, 'hF0F0, 'hFF00, 0, 0, 1, 0, 0, 0, 'hF000, 0, 0};
      vt[16] = '{0, 0, 4'h3, 'hF0F0, 'hFF00, 0, 0, 1, 0, 0, 0, 'hFFF0, 0, 0};
      vt[17] = '{0, 0, 4'hD, 'h8000_0000, 0, 8, 0, 1, 1, 0, 0, 0, 0, 8};
      vt[18] = '{1, 2, 4'h0, 0, 0, 'h100, 'h500, 1, 0, 1, 0, 'h504, 1, 'h600};

      step();
      step();
      chk_zero("reset32");
      rst32 = 0;

      memOpIn = 2'b10; memSizeIn = 2'b11;
      foreach (vt[i]) begin
         selA = vt[i].selA; selB = vt[i].selB; aluOp = vt[i].op;
         rs1 = vt[i].rs1; rs2 = vt[i].rs2; imm = vt[i].imm; pc = vt[i].pc;
         valid = vt[i].v; branch = vt[i].br; jal = vt[i].jl; jalr = vt[i].jr;
         step();
         chk($sformatf("vec%0d_result", i), ex_o, vt[i].e_res);
         chk($sformatf("vec%0d_pcSel", i), 64'(ps_o), 64'(vt[i].e_ps));
         chk($sformatf("vec%0d_pcVect", i), pv_o, vt[i].e_pv);
         chk($sformatf("vec%0d_outValid", i), 64'(ov_o), 64'(vt[i].v));
         chk($sformatf("vec%0d_memOp", i), 64'(mo_o), vt[i].v ? 64'd2 : 64'd0);
         chk($sformatf("vec%0d_memSize", i), 64'(ms_o), 64'd3);
         chk($sformatf("vec%0d_memDin", i), md_o, vt[i].rs2);
      end
      valid = 0; branch = 0; jal = 0; jalr = 0;

      run_md("div_m7_2", 3'd4, 64'hFFFF_FFF9, 2, 64'hFFFF_FFFD);
      run_md("rem_m7_2", 3'd6, 64'hFFFF_FFF9, 2, 64'hFFFF_FFFF);
      run_md("mulh_min", 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000);
      run_md("mulhu_ones", 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
      run_md("divu_by0", 3'd5, 9, 0, 64'hFFFF_FFFF);
      run_md("remu_by0", 3'd7, 9, 0, 9);
      run_md("div_ovf", 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
      run_md("rem_ovf", 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 0);
      run_md("mul_7_m3", 3'd0, 7, 64'hFFFF_FFFD, 64'hFFFF_FFEB);
      run_md("mulhsu_m1", 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);

      // DONE held by stallIn while the previous ALU result stays visible
      valid = 1; selA = 0; selB = 3; aluOp = 0; rs1 = 'h55;
      step();
      chk("pre_stall_alu", ex_o, 'h55);
      mdEn = 1; mdOp = 3'd3; rs1 = 'hFFFF_FFFF; rs2 = 'hFFFF_FFFF;
      step();
      valid = 0; mdEn = 0;
      for (int i = 0; i < 32; i++) step();
      chk("done_busy", 64'(busy_o), 1);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall%0d_busy", i), 64'(busy_o), 1);
         chk($sformatf("stall%0d_hold", i), ex_o, 'h55);
         chk($sformatf("stall%0d_outValid", i), 64'(ov_o), 0);
      end
      stall = 0;
      step();
      chk("unstall_result", ex_o, 'hFFFF_FFFE);
      chk("unstall_outValid", 64'(ov_o), 1);
      chk("unstall_busy", 64'(busy_o), 0);

      // stallIn in IDLE accepts nothing
      stall = 1; valid = 1; selB = 3; aluOp = 0; rs1 = 'h77;
      step();
      mdEn = 1; mdOp = 3'd4; rs2 = 3;
      step();
      chk("idle_stall_hold", ex_o, 'hFFFF_FFFE);
      chk("idle_stall_busy", 64'(busy_o), 0);
      mdEn = 0; stall = 0;
      step();
      chk("idle_unstall_result", ex_o, 'h77);
      valid = 0;

      // reset in the middle of a divide
      valid = 1; mdEn = 1; mdOp = 3'd4; rs1 = 100; rs2 = 7;
      step();
      for (int i = 0; i < 5; i++) step();
      rst32 = 1;
      step();
      chk_zero("midreset");
      rst32 = 0; mdEn = 0; valid = 1; selA = 0; selB = 1; aluOp = 0; rs1 = 'h10; imm = 'h20;
      step();
      chk("post_reset_add", ex_o, 'h30);
      chk("post_reset_outValid", 64'(ov_o), 1);
      chk("post_reset_busy", 64'(busy_o), 0);
      valid = 0;

      for (int i = 0; i < 40; i++) run_alu_rand();
      for (int i = 0; i < 20; i++) begin
         logic [2:0] op;
         logic [63:0] x, y;
         op = 3'($urandom); x = rnd_val(); y = rnd_val();
         run_md("rand_md32", op, x, y, md_ref(32, op, x, y));
      end

      w64 = 1; rst32 = 1; rst64 = 1;
      step();
      chk_zero("reset64");
      rst64 = 0;
      run_md("div64_m7_2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD);
      run_md("mulhu64_ones", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
      run_md("mulh64_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
      run_md("div64_ovf", 3'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
      for (int i = 0; i < 15; i++) run_alu_rand();
      for (int i = 0; i < 10; i++) begin
         logic [2:0] op;
         logic [63:0] x, y;
         op = 3'($urandom); x = rnd_val(); y = rnd_val();
         run_md("rand_md64", op, x, y, md_ref(64, op, x, y));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
